// File: rtl/hilo_div_sequencer.sv
// rtl/hilo_div_sequencer.sv - HI/LO owner and iterative-divider sequencer for DIV/DIVU/MTHI/MTLO
module hilo_div_sequencer #(
    parameter int WIDTH       = 32,
    parameter int DIV_TIMEOUT = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             rd_req,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             stall,
    output logic             div_rst,
    output logic [3:0]       div_ctrl,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_result,
    output logic             div_err
);

    localparam int TW = $clog2(DIV_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(DIV_TIMEOUT - 1);

    localparam logic [1:0] OP_DIVU = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_GETQ,
        S_GETR
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] quot;
    logic [TW-1:0]    timer;
    logic             div_signed;
    logic             accept;

    assign op_ready = (state == S_IDLE);
    assign accept   = op_valid & op_ready;
    assign stall    = rd_req & (state != S_IDLE);
    // No bypass: a read in the same cycle as an MTxx accept sees the old register.
    assign rd_data  = rd_sel ? hi : lo;

    // Sequencer FSM: drives the divider handshake and commits HI/LO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            hi         <= '0;
            lo         <= '0;
            quot       <= '0;
            div_a      <= '0;
            div_b      <= '0;
            div_rst    <= 1'b0;
            div_ctrl   <= 4'b0000;
            div_err    <= 1'b0;
            div_signed <= 1'b0;
            timer      <= '0;
        end else begin
            // div_rst is a single-cycle pulse covering only the START state.
            div_rst <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        div_err <= 1'b0;
                        case (op_code)
                            OP_MTHI: hi <= op_a;
                            OP_MTLO: lo <= op_a;
                            default: begin
                                if (op_b == '0) begin
                                    // Divide by zero never reaches the divider.
                                    hi      <= op_a;
                                    lo      <= '1;
                                    div_err <= 1'b1;
                                end else begin
                                    div_a      <= op_a;
                                    div_b      <= op_b;
                                    div_signed <= (op_code == OP_DIV);
                                    div_ctrl   <= {2'b11, (op_code == OP_DIV), 1'b0};
                                    div_rst    <= 1'b1;
                                    state      <= S_START;
                                end
                            end
                        endcase
                    end
                end
                S_START: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (div_done) begin
                        state <= S_GETQ;
                    end else if (timer == TIMER_LAST) begin
                        // Divider never finished: abandon, leave HI/LO untouched.
                        div_err <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_GETQ: begin
                    quot     <= div_result;
                    div_ctrl <= {2'b11, div_signed, 1'b1};
                    state    <= S_GETR;
                end
                S_GETR: begin
                    lo    <= quot;
                    hi    <= div_result;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div_sequencer.sv
// tb/tb_hilo_div_sequencer.sv - directed self-checking bench for hilo_div_sequencer
module tb_hilo_div_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  op_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        rd_req;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic        stall;
    logic        div_rst;
    logic [3:0]  div_ctrl;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_done;
    logic [31:0] div_result;
    logic        div_err;

    int n_checks = 0;
    int n_fail   = 0;

    hilo_div_sequencer #(.WIDTH(32), .DIV_TIMEOUT(40)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_a(op_a), .op_b(op_b),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data), .stall(stall),
        .div_rst(div_rst), .div_ctrl(div_ctrl), .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .div_result(div_result), .div_err(div_err)
    );

    always #5 clk = ~clk;

    // Divider stub: done pulse a fixed number of cycles after div_rst.
    logic [5:0] stub_cnt;
    logic       stub_done;
    logic       stub_en;
    logic       man_done;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            stub_cnt  <= 6'd0;
            stub_done <= 1'b0;
        end else begin
            stub_done <= 1'b0;
            if (div_rst) begin
                stub_cnt <= 6'd34;
            end else if (stub_cnt != 6'd0) begin
                stub_cnt <= stub_cnt - 6'd1;
                if (stub_cnt == 6'd1 && stub_en) stub_done <= 1'b1;
            end
        end
    end

    assign div_done = stub_done | man_done;

    // Divider result: sign-magnitude so INT_MIN / -1 is well defined.
    logic [31:0] mag_a, mag_b, uq, ur, sq, sr;
    always_comb begin
        mag_a = (div_ctrl[1] && div_a[31]) ? (32'd0 - div_a) : div_a;
        mag_b = (div_ctrl[1] && div_b[31]) ? (32'd0 - div_b) : div_b;
        uq    = (mag_b != 32'd0) ? (mag_a / mag_b) : 32'd0;
        ur    = (mag_b != 32'd0) ? (mag_a % mag_b) : 32'd0;
        sq    = (div_ctrl[1] && (div_a[31] ^ div_b[31])) ? (32'd0 - uq) : uq;
        sr    = (div_ctrl[1] && div_a[31]) ? (32'd0 - ur) : ur;
        div_result = div_ctrl[0] ? sr : sq;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] hi_exp, input logic [31:0] lo_exp);
        rd_sel = 1'b1;
        #1;
        check_eq({tag, "_hi"}, rd_data, hi_exp);
        rd_sel = 1'b0;
        #1;
        check_eq({tag, "_lo"}, rd_data, lo_exp);
    endtask

    // Present an op in IDLE; returns at the negedge after the accepting edge.
    task automatic issue(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = code;
        op_a     = a;
        op_b     = b;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, output int cycles);
        cycles = 0;
        while (!op_ready && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        if (!op_ready) check_eq({tag, "_idle"}, {31'd0, op_ready}, 32'd1);
    endtask

    int  cyc;
    logic stall_ok;

    initial begin
        rst = 1'b0; op_valid = 1'b0; op_code = 2'b00; op_a = '0; op_b = '0;
        rd_req = 1'b0; rd_sel = 1'b0; stub_en = 1'b1; man_done = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", {31'd0, op_ready}, 32'd1);
        check_eq("rst_divrst", {31'd0, div_rst}, 32'd0);
        check_eq("rst_ctrl", {28'd0, div_ctrl}, 32'd0);
        check_eq("rst_err", {31'd0, div_err}, 32'd0);
        check_hilo("rst", 32'd0, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // DIVU 100 / 7
        issue(2'b00, 32'h0000_0064, 32'h0000_0007);
        check_eq("t1_start_pulse", {31'd0, div_rst}, 32'd1);
        check_eq("t1_ctrl", {28'd0, div_ctrl}, 32'h0000_000C);
        check_eq("t1_busy", {31'd0, op_ready}, 32'd0);
        @(negedge clk);
        check_eq("t1_pulse_end", {31'd0, div_rst}, 32'd0);
        wait_idle("t1", cyc);
        check_hilo("t1", 32'h0000_0002, 32'h0000_000E);
        check_eq("t1_err", {31'd0, div_err}, 32'd0);

        // DIV -100 / 7
        issue(2'b01, 32'hFFFF_FF9C, 32'h0000_0007);
        check_eq("t2_ctrl", {28'd0, div_ctrl}, 32'h0000_000E);
        wait_idle("t2", cyc);
        check_hilo("t2", 32'hFFFF_FFFE, 32'hFFFF_FFF2);

        // DIV INT_MIN / -1
        issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("t2b", cyc);
        check_hilo("t2b", 32'h0000_0000, 32'h8000_0000);

        // DIVU by zero
        issue(2'b00, 32'h1234_5678, 32'h0000_0000);
        check_eq("t3_no_pulse", {31'd0, div_rst}, 32'd0);
        check_eq("t3_ready", {31'd0, op_ready}, 32'd1);
        check_eq("t3_err", {31'd0, div_err}, 32'd1);
        check_hilo("t3", 32'h1234_5678, 32'hFFFF_FFFF);
        @(negedge clk);
        check_eq("t3_no_pulse2", {31'd0, div_rst}, 32'd0);

        // MTLO: same-cycle read sees old LO; accept clears div_err
        @(negedge clk);
        op_valid = 1'b1; op_code = 2'b11; op_a = 32'h5A5A_5A5A; op_b = '0;
        rd_sel = 1'b0;
        #1;
        check_eq("mt_no_bypass", rd_data, 32'hFFFF_FFFF);
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        check_eq("mt_err_clr", {31'd0, div_err}, 32'd0);
        issue(2'b10, 32'hA5A5_A5A5, 32'h0);
        check_hilo("mt", 32'hA5A5_A5A5, 32'h5A5A_5A5A);

        // Timeout: divider never completes
        stub_en = 1'b0;
        issue(2'b00, 32'h0000_0009, 32'h0000_0003);
        wait_idle("t5", cyc);
        check_eq("t5_cycles", cyc, 32'd41);
        check_eq("t5_err", {31'd0, div_err}, 32'd1);
        check_hilo("t5", 32'hA5A5_A5A5, 32'h5A5A_5A5A);
        stub_en = 1'b1;

        // MFLO one cycle after DIVU accept stalls until commit
        issue(2'b00, 32'd1000, 32'd10);
        rd_req = 1'b1; rd_sel = 1'b0;
        #1;
        check_eq("t4_stall_on", {31'd0, stall}, 32'd1);
        stall_ok = 1'b1;
        cyc = 0;
        while (!op_ready && cyc < 200) begin
            if (!stall) stall_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        #1;
        check_eq("t4_idle", {31'd0, op_ready}, 32'd1);
        check_eq("t4_stall_held", {31'd0, stall_ok}, 32'd1);
        check_eq("t4_stall_off", {31'd0, stall}, 32'd0);
        check_eq("t4_rd_lo", rd_data, 32'h0000_0064);
        rd_req = 1'b0;
        check_eq("t4_err", {31'd0, div_err}, 32'd0);

        // Async reset during WAIT
        issue(2'b00, 32'h0000_0064, 32'h0000_0007);
        repeat (5) @(negedge clk);
        check_eq("t6_busy", {31'd0, op_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("t6_ready", {31'd0, op_ready}, 32'd1);
        check_eq("t6_divrst", {31'd0, div_rst}, 32'd0);
        check_eq("t6_err", {31'd0, div_err}, 32'd0);
        check_hilo("t6", 32'd0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        @(negedge clk);
        check_eq("t6_late_done", {31'd0, op_ready}, 32'd1);
        check_eq("t6_late_pulse", {31'd0, div_rst}, 32'd0);
        check_hilo("t6_late", 32'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
